// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages that advance into any
// free slot downstream, with a synchronous flush and an occupancy count.
module dff_pipe #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           dout,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] d_src [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_src;
  logic [DEPTH-1:0] rdy;
  logic             accept;

  // A stage can take a new beat if it is empty or its own beat moves on.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    rdy            = '0;
    rdy[DEPTH-1]   = !v[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--) begin
      rdy[i] = !v[i] | rdy[i+1];
    end
  end

  assign in_ready = rdy[0] & !flush & reset;
  assign accept   = in_valid & in_ready;

  // Source of each stage: the accepted input beat for stage 0, else the
  // stage immediately upstream.
  always_comb begin
    v_src    = '0;
    d_src[0] = din;
    v_src[0] = accept;
    for (int i = 1; i < DEPTH; i++) begin
      v_src[i] = v[i-1];
      d_src[i] = d[i-1];
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples its upstream neighbour's pre-edge value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) v[i] <= v_src[i];
      end
    end
  end

  // NOTE: the data stages are reset as well because dout must read RESET_VAL
  // while reset is held; flush leaves data untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= RESET_VAL;
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && v_src[i]) d[i] <= d_src[i];
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(v[i]);
    end
  end

  assign dout      = d[DEPTH-1];
  assign out_valid = v[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Directed and scoreboarded checks of dff_pipe at DEPTH=4 (RESET_VAL=0x3C)
// and DEPTH=1.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, flush;
  logic [7:0] din, dout;
  logic [2:0] count;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, flush1;
  logic [7:0] din1, dout1;
  logic [0:0] count1;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] q [$];
  logic [7:0] seq = 8'd0;
  int         accepted = 0;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h3C)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .flush(flush), .count(count)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .din(din1), .out_valid(out_valid1), .out_ready(out_ready1), .dout(dout1),
    .flush(flush1), .count(count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cycle(input logic iv, input logic ordy);
    in_valid  = iv;
    out_ready = ordy;
    din       = seq;
    @(negedge clk);
    check("rnd_count", 32'(count), 32'(q.size()));
    check("rnd_in_ready", 32'(in_ready), 32'((q.size() < 4) | ordy));
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("rnd_spurious", 32'(out_valid), 32'd0);
      else               check("rnd_data", 32'(dout), 32'(q.pop_front()));
    end
    if (in_valid && in_ready) begin
      q.push_back(din);
      seq = seq + 8'd1;
      accepted++;
    end
    step();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; din = 8'h00; flush = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; din1 = 8'h00; flush1 = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout", 32'(dout), 32'h3C);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_dout_d1", 32'(dout1), 32'h00);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Streaming 0x01..0x08 with out_ready held high.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      din = 8'(k);
      step();
      check($sformatf("stream_count_%0d", k), 32'(count), 32'((k < 4) ? k : 4));
      if (k >= 4) begin
        check($sformatf("stream_dout_%0d", k), 32'(dout), 32'(k - 3));
        check($sformatf("stream_ov_%0d", k), 32'(out_valid), 32'd1);
      end
    end
    in_valid = 1'b0;
    for (int k = 9; k <= 11; k++) begin
      step();
      check($sformatf("stream_drain_%0d", k), 32'(dout), 32'(k - 3));
    end
    step();
    check("stream_empty_ov", 32'(out_valid), 32'd0);
    check("stream_empty_count", 32'(count), 32'd0);

    // Backpressure: fill with 0xA0..0xA3 while the sink stalls.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 8'hA0 + 8'(k);
      step();
    end
    check("bp_full_count", 32'(count), 32'd4);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_full_dout", 32'(dout), 32'hA0);
    din = 8'hA4; out_ready = 1'b1;
    #1;
    check("bp_pushpop_in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_pushpop_dout", 32'(dout), 32'hA1);
    check("bp_pushpop_count", 32'(count), 32'd4);
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("bp_hold_dout", 32'(dout), 32'hA1);
    check("bp_hold_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      step();
      check($sformatf("bp_drain_%0d", k), 32'(dout), 32'hA0 + 32'(k));
    end
    step();
    check("bp_empty_ov", 32'(out_valid), 32'd0);

    // Flush with three beats in flight and a beat offered on din.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = 8'hB0 + 8'(k);
      step();
    end
    check("fl_pre_count", 32'(count), 32'd3);
    din = 8'hEE; flush = 1'b1; out_ready = 1'b1;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    step();
    check("fl_count", 32'(count), 32'd0);
    check("fl_ov", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("fl_after_ov_%0d", k), 32'(out_valid), 32'd0);
    end
    check("fl_after_count", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle with a full pipeline.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 8'hC0 + 8'(k);
      step();
    end
    check("ar_pre_count", 32'(count), 32'd4);
    check("ar_pre_dout", 32'(dout), 32'hC0);
    #3 reset = 1'b0;
    #1;
    check("ar_ov", 32'(out_valid), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_dout", 32'(dout), 32'h3C);
    check("ar_in_ready", 32'(in_ready), 32'd0);
    step();
    check("ar_held_in_ready", 32'(in_ready), 32'd0);
    check("ar_held_count", 32'(count), 32'd0);
    @(negedge clk);
    reset = 1'b1; din = 8'hD0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    check("ar_first_accept", 32'(count), 32'd1);
    in_valid = 1'b0;
    step();
    step();
    check("ar_lat_not_yet", 32'(out_valid), 32'd0);
    step();
    check("ar_lat_ov", 32'(out_valid), 32'd1);
    check("ar_lat_dout", 32'(dout), 32'hD0);
    step();

    // DEPTH=1 instance.
    in_valid1 = 1'b1; out_ready1 = 1'b1; din1 = 8'h5A;
    step();
    check("d1_dout_5a", 32'(dout1), 32'h5A);
    check("d1_ov_5a", 32'(out_valid1), 32'd1);
    din1 = 8'h5B;
    #1;
    check("d1_in_ready", 32'(in_ready1), 32'd1);
    step();
    check("d1_dout_5b", 32'(dout1), 32'h5B);
    out_ready1 = 1'b0; din1 = 8'h5C;
    step();
    check("d1_stall_dout", 32'(dout1), 32'h5B);
    check("d1_stall_in_ready", 32'(in_ready1), 32'd0);
    check("d1_stall_count", 32'(count1), 32'd1);
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    step();
    check("d1_empty_ov", 32'(out_valid1), 32'd0);

    // Random valid/ready traffic against a scoreboard, then drain.
    for (int c = 0; c < 10000; c++) begin
      rnd_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int c = 0; c < 8; c++) begin
      rnd_cycle(1'b0, 1'b1);
    end
    check("rnd_drained", 32'(q.size()), 32'd0);
    check("rnd_progress", 32'(accepted > 1000), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
